board_renderer: RTL

- Reads the game core's board (flat_board plus the four active-block coordinates) and turns it into a stream of pixel writes for the VGA adapter.
- The game core writes board state; this block is the reader/drawing end of that interface.
- On each start_frame it snapshots the inputs and scans the 20 visible rows x 10 columns. Each cell is drawn as a CELL_SIZE x CELL_SIZE square through a valid/ready pixel handshake.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/board_cell_lookup.sv | 40 ++++
 rtl/board_renderer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, default colours and renderer state encoding.
package tetris_pkg;

    localparam int BOARD_ROWS   = 23;
    localparam int VISIBLE_ROWS = 20;
    localparam int BOARD_COLS   = 10;

    localparam logic [2:0] DEF_COLOUR_BOARD = 3'b111;
    localparam logic [2:0] DEF_COLOUR_BLOCK = 3'b100;
    localparam logic [2:0] DEF_COLOUR_EMPTY = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } render_state_t;

endpackage

// File: rtl/board_cell_lookup.sv
// Combinational colour lookup for one visible cell of the snapshot board.
module board_cell_lookup
    import tetris_pkg::*;
#(
    parameter logic [2:0] COLOUR_BOARD = DEF_COLOUR_BOARD,
    parameter logic [2:0] COLOUR_BLOCK = DEF_COLOUR_BLOCK,
    parameter logic [2:0] COLOUR_EMPTY = DEF_COLOUR_EMPTY
) (
    input  logic [VISIBLE_ROWS*BOARD_COLS-1:0] board,
    input  logic [15:0]                        block_x,
    input  logic [19:0]                        block_y,
    input  logic [4:0]                         row,
    input  logic [3:0]                         col,
    output logic [2:0]                         colour
);

    logic       block_hit;
    logic [7:0] bit_idx;

    // Active-block cells override the settled board; off-screen blocks never match.
    always_comb begin
        block_hit = 1'b0;
        bit_idx   = 8'(row) * 8'(BOARD_COLS) + 8'(col);
        for (int k = 0; k < 4; k++) begin
            if ((block_y[k*5 +: 5] == row) &&
                (block_y[k*5 +: 5] < 5'(VISIBLE_ROWS)) &&
                (block_x[k*4 +: 4] == col)) begin
                block_hit = 1'b1;
            end
        end
        if (block_hit) begin
            colour = COLOUR_BLOCK;
        end else if (board[bit_idx]) begin
            colour = COLOUR_BOARD;
        end else begin
            colour = COLOUR_EMPTY;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Snapshots the game board on start_frame and streams it as CELL_SIZE^2
// pixel squares per cell over a valid/ready pixel interface.
module board_renderer
    import tetris_pkg::*;
#(
    parameter int         CELL_SIZE    = 4,
    parameter int         ORIGIN_X     = 60,
    parameter int         ORIGIN_Y     = 20,
    parameter logic [2:0] COLOUR_BOARD = DEF_COLOUR_BOARD,
    parameter logic [2:0] COLOUR_BLOCK = DEF_COLOUR_BLOCK,
    parameter logic [2:0] COLOUR_EMPTY = DEF_COLOUR_EMPTY
) (
    input  logic                            clock_framerate,
    input  logic                            resetn,
    input  logic                            start_frame,
    input  logic [BOARD_ROWS*BOARD_COLS-1:0] flat_board,
    input  logic [3:0]                      block1_x,
    input  logic [3:0]                      block2_x,
    input  logic [3:0]                      block3_x,
    input  logic [3:0]                      block4_x,
    input  logic [4:0]                      block1_y,
    input  logic [4:0]                      block2_y,
    input  logic [4:0]                      block3_y,
    input  logic [4:0]                      block4_y,
    input  logic                            plot_ready,
    output logic                            plot_valid,
    output logic [7:0]                      plot_x,
    output logic [6:0]                      plot_y,
    output logic [2:0]                      plot_colour,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int             CW   = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam logic [CW-1:0]  CMAX = CW'(CELL_SIZE - 1);

    render_state_t state, next_state;

    logic [VISIBLE_ROWS*BOARD_COLS-1:0] snap_board;
    logic [15:0]   snap_bx;
    logic [19:0]   snap_by;
    logic [4:0]    row;
    logic [3:0]    col;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic          accept;
    logic          last_pixel;
    logic [2:0]    cell_colour;
    logic          unused_hidden_rows;

    // Rows above the visible field are deliberately never read.
    assign unused_hidden_rows = &{1'b0, flat_board[BOARD_ROWS*BOARD_COLS-1:VISIBLE_ROWS*BOARD_COLS]};

    assign accept     = (state == SCAN) && plot_ready;
    assign last_pixel = (row == 5'd0) && (col == 4'(BOARD_COLS - 1)) &&
                        (dy == CMAX) && (dx == CMAX);

    board_cell_lookup #(
        .COLOUR_BOARD (COLOUR_BOARD),
        .COLOUR_BLOCK (COLOUR_BLOCK),
        .COLOUR_EMPTY (COLOUR_EMPTY)
    ) u_lookup (
        .board   (snap_board),
        .block_x (snap_bx),
        .block_y (snap_by),
        .row     (row),
        .col     (col),
        .colour  (cell_colour)
    );

    // State register.
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; pixel fields are derived from the scan counters.
    always_comb begin
        next_state  = state;
        plot_valid  = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        plot_x      = 8'd0;
        plot_y      = 7'd0;
        plot_colour = 3'd0;
        case (state)
            IDLE: begin
                if (start_frame) next_state = SNAP;
            end
            SNAP: begin
                busy       = 1'b1;
                next_state = SCAN;
            end
            SCAN: begin
                busy        = 1'b1;
                plot_valid  = 1'b1;
                plot_x      = 8'(ORIGIN_X + int'(col) * CELL_SIZE + int'(dx));
                plot_y      = 7'(ORIGIN_Y + (VISIBLE_ROWS - 1 - int'(row)) * CELL_SIZE + int'(dy));
                plot_colour = cell_colour;
                if (accept && last_pixel) next_state = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the visible board and block positions so the frame is isolated from later changes.
    always_ff @(posedge clock_framerate) begin
        if (state == SNAP) begin
            snap_board <= flat_board[VISIBLE_ROWS*BOARD_COLS-1:0];
            snap_bx    <= {block4_x, block3_x, block2_x, block1_x};
            snap_by    <= {block4_y, block3_y, block2_y, block1_y};
        end
    end

    // Scan counters: dx fastest, then dy, then col, then row counting down from the top.
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            row <= 5'd0;
            col <= 4'd0;
            dx  <= '0;
            dy  <= '0;
        end else if (state == SNAP) begin
            row <= 5'(VISIBLE_ROWS - 1);
            col <= 4'd0;
            dx  <= '0;
            dy  <= '0;
        end else if (accept) begin
            if (dx != CMAX) begin
                dx <= dx + 1'b1;
            end else begin
                dx <= '0;
                if (dy != CMAX) begin
                    dy <= dy + 1'b1;
                end else begin
                    dy <= '0;
                    if (col != 4'(BOARD_COLS - 1)) begin
                        col <= col + 4'd1;
                    end else begin
                        col <= 4'd0;
                        if (row != 5'd0) row <= row - 5'd1;
                    end
                end
            end
        end
    end

endmodule
